fetch_unit: RTL

//  Instruction-fetch stage upstream of instruction_memory. Holds the PC and drives
//  the byte address into the combinational instruction memory. Captures
//  {pc, instruction} pairs into a small queue and hands them to decode over a

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic {
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instruction} entries; flush beats push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Head is read straight out of registered storage, zeroed when empty.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, fetch queue, redirect handling and fault/done status.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     IMEM_BYTES = 88,
  parameter int unsigned     DEPTH      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] inst_address,
  input  logic [ILEN-1:0] instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            done,
  output logic            fault
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            push, pop, flush;
  logic            q_full, q_empty;
  logic            in_range;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign inst_address = pc;
  assign in_range     = pc < XLEN'(IMEM_BYTES);
  assign push_entry   = '{pc: pc, instr: instruction};
  assign pop          = out_valid && out_ready;

  assign out_valid = !q_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign done      = !in_range && q_empty;
  assign fault     = (state == FAULT);

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .din    (push_entry),
    .head   (head),
    .full   (q_full),
    .empty  (q_empty)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Redirect beats fetch; a misaligned target flushes and parks the unit in FAULT
  // with the PC left where it was.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (is_aligned(redirect_pc)) begin
            pc_next = redirect_pc;
          end else begin
            state_next = FAULT;
          end
        end else if (in_range && (!q_full || pop)) begin
          push    = 1'b1;
          pc_next = pc + XLEN'(4);
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

endmodule
